// File: rtl/register_unmapper_pkg.sv
// rtl/register_unmapper_pkg.sv - shared constants and types for the register unmapper
package register_map_pkg;

    localparam int NUM_REGS = 4;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int DATA_W   = 8;

    typedef logic [IDX_W-1:0]                 reg_idx_t;
    typedef logic [DATA_W-1:0]                reg_data_t;
    typedef logic [NUM_REGS-1:0][IDX_W-1:0]   perm_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        PRESENT,
        DONE
    } dump_state_e;

endpackage

// File: rtl/register_unmapper_if.sv
// rtl/register_unmapper_if.sv - regfile read port and dump stream bundle
interface register_unmapper_if;
    import register_map_pkg::*;

    reg_idx_t  rf_rd_addr;
    reg_data_t rf_rd_data;
    logic      dump_valid;
    logic      dump_ready;
    reg_idx_t  dump_log_idx;
    reg_data_t dump_data;

    modport master (
        output rf_rd_addr,
        input  rf_rd_data,
        output dump_valid,
        input  dump_ready,
        output dump_log_idx,
        output dump_data
    );

    modport slave (
        input  rf_rd_addr,
        output rf_rd_data,
        input  dump_valid,
        output dump_ready,
        input  dump_log_idx,
        input  dump_data
    );

endinterface

// File: rtl/register_unmapper_table.sv
// rtl/register_unmapper_table.sv - forward/inverse permutation tables updated by SWAP
module swap_perm_table
    import register_map_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     do_swap,
    input  reg_idx_t swap_a,
    input  reg_idx_t swap_b,
    input  reg_idx_t phys_idx,
    output perm_t    inv,
    output reg_idx_t log_idx
);

    perm_t fwd_q;
    perm_t inv_q;

    // Both tables move together so I[F[l]] == l holds after every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                fwd_q[i] <= reg_idx_t'(i);
                inv_q[i] <= reg_idx_t'(i);
            end
        end else if (do_swap && (swap_a != swap_b)) begin
            fwd_q[swap_a]        <= fwd_q[swap_b];
            fwd_q[swap_b]        <= fwd_q[swap_a];
            inv_q[fwd_q[swap_a]] <= swap_b;
            inv_q[fwd_q[swap_b]] <= swap_a;
        end
    end

    assign inv     = inv_q;
    assign log_idx = inv_q[phys_idx];

endmodule

// File: rtl/register_unmapper.sv
// rtl/register_unmapper.sv - physical->logical register unmapper with snapshot dump sequencer
module register_unmapper
    import register_map_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 do_swap,
    input  reg_idx_t             swap_a,
    input  reg_idx_t             swap_b,
    input  reg_idx_t             phys_idx,
    output reg_idx_t             log_idx,
    input  logic                 dump_start,
    output logic                 dump_busy,
    output logic                 dump_done,
    register_unmapper_if.master  dump_if
);

    localparam reg_idx_t LAST_P = reg_idx_t'(NUM_REGS - 1);

    perm_t       inv;
    perm_t       snap_q;
    dump_state_e state_q, state_d;
    reg_idx_t    p_q;
    reg_idx_t    beat_log_q;
    reg_data_t   beat_data_q;
    logic        fresh_q;
    logic        accept;

    swap_perm_table u_table (
        .clk      (clk),
        .reset    (reset),
        .do_swap  (do_swap),
        .swap_a   (swap_a),
        .swap_b   (swap_b),
        .phys_idx (phys_idx),
        .inv      (inv),
        .log_idx  (log_idx)
    );

    assign accept = (state_q == PRESENT) && dump_if.dump_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            p_q         <= '0;
            snap_q      <= '0;
            beat_log_q  <= '0;
            beat_data_q <= '0;
            fresh_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        p_q    <= '0;
                        snap_q <= inv;
                    end
                end
                READ: begin
                    beat_log_q <= snap_q[p_q];
                    fresh_q    <= 1'b1;
                end
                PRESENT: begin
                    // Regfile data arrives in the first PRESENT cycle; hold it while stalled.
                    if (fresh_q) begin
                        beat_data_q <= dump_if.rf_rd_data;
                        fresh_q     <= 1'b0;
                    end
                    if (accept && (p_q != LAST_P)) begin
                        p_q <= reg_idx_t'(p_q + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d            = state_q;
        dump_if.rf_rd_addr = p_q;
        dump_if.dump_valid = 1'b0;
        dump_busy          = 1'b1;
        dump_done          = 1'b0;
        case (state_q)
            IDLE: begin
                dump_busy          = 1'b0;
                dump_if.rf_rd_addr = '0;
                if (dump_start) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = PRESENT;
            end
            PRESENT: begin
                dump_if.dump_valid = 1'b1;
                if (accept) begin
                    state_d = (p_q == LAST_P) ? DONE : READ;
                end
            end
            DONE: begin
                dump_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dump_if.dump_log_idx = beat_log_q;
    assign dump_if.dump_data    = ((state_q == PRESENT) && fresh_q) ? dump_if.rf_rd_data
                                                                     : beat_data_q;

endmodule

// File: tb/tb_register_unmapper.sv
// tb/tb_register_unmapper.sv - randomized self-checking bench for register_unmapper
module tb_register_unmapper;
    import register_map_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    logic     do_swap;
    reg_idx_t swap_a, swap_b, phys_idx, log_idx;
    logic     dump_start, dump_busy, dump_done;

    register_unmapper_if bus ();

    register_unmapper dut (
        .clk        (clk),
        .reset      (reset),
        .do_swap    (do_swap),
        .swap_a     (swap_a),
        .swap_b     (swap_b),
        .phys_idx   (phys_idx),
        .log_idx    (log_idx),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_if    (bus)
    );

    always #5 clk = ~clk;

    reg_data_t rf_mem [NUM_REGS];
    always @(posedge clk) bus.rf_rd_data <= rf_mem[bus.rf_rd_addr];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: permutation arrays plus a queue of pending beats.
    typedef struct { int li; int d; } beat_t;
    int    fm [NUM_REGS];
    int    im [NUM_REGS];
    beat_t mq [$];
    bit    m_read, m_done;
    int    la, lb, pa, pb;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                fm[i] = i;
                im[i] = i;
            end
            mq.delete();
            m_read = 0;
            m_done = 0;
        end else begin
            if (m_done) begin
                m_done = 0;
            end else if (mq.size() != 0) begin
                if (m_read) begin
                    m_read = 0;
                end else if (bus.dump_ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_done = 1;
                    else m_read = 1;
                end
            end else if (dump_start) begin
                for (int p = 0; p < NUM_REGS; p++) mq.push_back('{im[p], int'(rf_mem[p])});
                m_read = 1;
            end
            if (do_swap) begin
                la = int'(swap_a);
                lb = int'(swap_b);
                pa = fm[la];
                pb = fm[lb];
                fm[la] = pb;
                fm[lb] = pa;
                im[pa] = lb;
                im[pb] = la;
            end
        end
    end

    always @(negedge clk) begin
        check("q_log_idx", log_idx, im[phys_idx]);
        check("dump_valid", bus.dump_valid, (mq.size() != 0 && !m_read));
        check("dump_busy", dump_busy, (mq.size() != 0 || m_done));
        check("dump_done", dump_done, m_done);
        if (mq.size() != 0 && !m_read && bus.dump_valid) begin
            check("beat_log", bus.dump_log_idx, mq[0].li);
            check("beat_data", bus.dump_data, mq[0].d);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic swap(input int a, input int b);
        do_swap = 1'b1;
        swap_a  = reg_idx_t'(a);
        swap_b  = reg_idx_t'(b);
        step();
        do_swap = 1'b0;
    endtask

    task automatic check_table(string name, input int e0, input int e1, input int e2, input int e3);
        int exp_t [NUM_REGS];
        exp_t = '{e0, e1, e2, e3};
        for (int i = 0; i < NUM_REGS; i++) begin
            phys_idx = reg_idx_t'(i);
            #1;
            check(name, log_idx, exp_t[i]);
        end
    endtask

    int got_li [$];
    int got_d  [$];
    int done_cyc, n_done, n_beats;

    // Dump with ready high from the start edge; records beats and done cycle.
    task automatic run_dump_ready_high(input int swap_cycle);
        got_li.delete();
        got_d.delete();
        done_cyc = -1;
        n_done   = 0;
        bus.dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (bus.dump_valid && bus.dump_ready) begin
                got_li.push_back(int'(bus.dump_log_idx));
                got_d.push_back(int'(bus.dump_data));
            end
            if (dump_done) begin
                n_done++;
                done_cyc = c;
            end
            if (c == swap_cycle) begin
                do_swap = 1'b1;
                swap_a  = 2'd0;
                swap_b  = 2'd3;
            end
            step();
            do_swap = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        do_swap = 1'b0;
        swap_a = '0;
        swap_b = '0;
        phys_idx = '0;
        dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
        step();
        #1;
        check("rst_valid", bus.dump_valid, 0);
        check("rst_busy", dump_busy, 0);
        check("rst_done", dump_done, 0);
        check("rst_data", bus.dump_data, 0);
        reset = 1'b0;
        step();

        check_table("t1_identity", 0, 1, 2, 3);

        swap(0, 2);
        check_table("t2_swap02", 2, 1, 0, 3);
        swap(0, 2);
        check_table("t2_restore", 0, 1, 2, 3);

        swap(1, 1);
        check_table("t3_swap11", 0, 1, 2, 3);
        swap(0, 1);
        swap(1, 3);
        check_table("t3_table", 3, 0, 2, 1);

        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = reg_data_t'(8'hA0 + i);
        run_dump_ready_high(-1);
        check("t4_nbeats", got_li.size(), 4);
        if (got_li.size() == 4) begin
            check("t4_b0_log", got_li[0], 3);  check("t4_b0_data", got_d[0], 8'hA0);
            check("t4_b1_log", got_li[1], 0);  check("t4_b1_data", got_d[1], 8'hA1);
            check("t4_b2_log", got_li[2], 2);  check("t4_b2_data", got_d[2], 8'hA2);
            check("t4_b3_log", got_li[3], 1);  check("t4_b3_data", got_d[3], 8'hA3);
        end
        check("t4_done_count", n_done, 1);
        check("t4_done_cycle", done_cyc, 9);

        // Toggling ready: model checker verifies stability and ordering each cycle.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = reg_data_t'($urandom);
            n_beats = 0;
            n_done  = 0;
            dump_start = 1'b1;
            bus.dump_ready = 1'b0;
            step();
            dump_start = 1'b0;
            for (int c = 0; c < 60 && n_done == 0; c++) begin
                bus.dump_ready = (r == 0) ? logic'(c % 2) : logic'($urandom_range(0, 1));
                #1;
                if (bus.dump_valid && bus.dump_ready) n_beats++;
                if (dump_done) n_done++;
                step();
            end
            check("t5_beats", n_beats, 4);
            check("t5_done_seen", n_done, 1);
        end

        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = reg_data_t'(8'h50 + i);
        run_dump_ready_high(4);
        check("t6_nbeats", got_li.size(), 4);
        if (got_li.size() == 4) begin
            for (int i = 0; i < NUM_REGS; i++) check("t6_snap_log", got_li[i], i);
        end
        phys_idx = 2'd0;
        #1;
        check("t6_post_q0", log_idx, 3);

        dump_start = 1'b1;
        bus.dump_ready = 1'b1;
        step();
        dump_start = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("t6_rst_busy", dump_busy, 0);
        check("t6_rst_valid", bus.dump_valid, 0);
        check("t6_rst_done", dump_done, 0);
        step();
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            if (dump_done) n_done++;
            step();
        end
        check("t6_no_done", n_done, 0);
        check_table("t6_identity", 0, 1, 2, 3);

        // Random mix of swaps, queries, starts and backpressure.
        for (int c = 0; c < 400; c++) begin
            do_swap        = logic'($urandom_range(0, 2) == 0);
            swap_a         = reg_idx_t'($urandom);
            swap_b         = reg_idx_t'($urandom);
            phys_idx       = reg_idx_t'($urandom);
            dump_start     = logic'($urandom_range(0, 4) == 0);
            bus.dump_ready = logic'($urandom_range(0, 2) != 0);
            if (!dump_busy) begin
                for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = reg_data_t'($urandom);
            end
            step();
        end
        do_swap = 1'b0;
        dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
